// File: rtl/soc_bus_pkg.sv
// Shared types and constants for the SoC memory arbiter.
package soc_bus_pkg;

    // Transaction sequencer states; exactly one transaction is in flight.
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    // Default word address of the memory-mapped halt register.
    localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h1000_0000;

    // Zero response word, sliced down to the data width in use.
    localparam int unsigned          RSP_ZERO_MAX_W = 1024;
    localparam logic [RSP_ZERO_MAX_W-1:0] RSP_ZERO  = '0;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
    parameter  int unsigned N  = 2,
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic [PW-1:0] idx;
    logic          found;

    // Scan N positions starting at ptr and grant the first active request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PW'((32'(ptr) + i) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_mem_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM among
// NUM_PORTS requesters, with a memory-mapped halt register.
module soc_mem_arb
    import soc_bus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned NUM_PORTS   = 2,
    parameter int unsigned MEM_LATENCY = 1,
    parameter logic [ADDR_WIDTH-1:0] HALT_ADDR = ADDR_WIDTH'(HALT_ADDR_DEFAULT)
) (
    input  logic                              i_sys_clk,
    input  logic                              i_sys_rst_n,
    input  logic [NUM_PORTS-1:0]              i_req_valid,
    output logic [NUM_PORTS-1:0]              o_req_ready,
    input  logic [NUM_PORTS-1:0]              i_req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] i_req_wstrb,
    output logic [NUM_PORTS-1:0]              o_rsp_valid,
    output logic [DATA_WIDTH-1:0]             o_rsp_rdata,
    output logic                              o_mem_en,
    output logic                              o_mem_we,
    output logic [ADDR_WIDTH-1:0]             o_mem_addr,
    output logic [DATA_WIDTH-1:0]             o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0]           o_mem_wstrb,
    input  logic [DATA_WIDTH-1:0]             i_mem_rdata,
    output logic                              o_end_flag,
    output logic [DATA_WIDTH-1:0]             o_end_data
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW = $clog2(MEM_LATENCY + 1);
    localparam int unsigned SW = DATA_WIDTH / 8;

    state_e                state_q,    state_d;
    logic [PW-1:0]         rr_ptr_q,   rr_ptr_d;
    logic [PW-1:0]         port_q,     port_d;
    logic                  we_q,       we_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [SW-1:0]         wstrb_q,    wstrb_d;
    logic [CW-1:0]         cnt_q,      cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q,    rdata_d;
    logic                  end_flag_q, end_flag_d;
    logic [DATA_WIDTH-1:0] end_data_q, end_data_d;

    logic [NUM_PORTS-1:0]  gnt;
    logic [PW-1:0]         gnt_idx;
    logic                  is_halt;
    logic                  mem_issue;

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_rr_arbiter (
        .req     (i_req_valid),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign is_halt   = (addr_q == HALT_ADDR);
    assign mem_issue = (state_q == ISSUE) && !is_halt;

    // Next-state, transaction capture and halt-register update.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        port_d     = port_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        end_flag_d = end_flag_q;
        end_data_d = end_data_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    state_d  = ISSUE;
                    port_d   = gnt_idx;
                    we_d     = i_req_we[gnt_idx];
                    addr_d   = i_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d  = i_req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                    wstrb_d  = i_req_wstrb[gnt_idx*SW +: SW];
                    rr_ptr_d = (32'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PW'(1);
                end
            end
            ISSUE: begin
                if (is_halt && we_q && !end_flag_q) begin
                    end_flag_d = 1'b1;
                    end_data_d = wdata_q;
                end
                cnt_d   = CW'(MEM_LATENCY - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (we_q) begin
                        rdata_d = RSP_ZERO[DATA_WIDTH-1:0];
                    end else if (is_halt) begin
                        rdata_d = DATA_WIDTH'(end_flag_q);
                    end else begin
                        rdata_d = i_mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any transaction in flight.
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            port_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            end_flag_q <= 1'b0;
            end_data_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            port_q     <= port_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            end_flag_q <= end_flag_d;
            end_data_q <= end_data_d;
        end
    end

    // Outputs decoded from the registered state; memory bus is zero outside ISSUE.
    always_comb begin
        o_req_ready = (state_q == IDLE) ? gnt : '0;
        o_mem_en    = mem_issue;
        o_mem_we    = mem_issue & we_q;
        o_mem_addr  = mem_issue ? addr_q  : '0;
        o_mem_wdata = mem_issue ? wdata_q : '0;
        o_mem_wstrb = mem_issue ? wstrb_q : '0;
        o_rsp_valid = (state_q == RESP) ? (NUM_PORTS'(1) << port_q) : '0;
        o_rsp_rdata = (state_q == RESP) ? rdata_q : '0;
        o_end_flag  = end_flag_q;
        o_end_data  = end_data_q;
    end

endmodule

// File: tb/tb_soc_mem_arb.sv
module tb_soc_mem_arb;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  req_valid [NI];
    logic [1:0]  req_we    [NI];
    logic [63:0] req_addr  [NI];
    logic [63:0] req_wdata [NI];
    logic [7:0]  req_wstrb [NI];
    logic [1:0]  req_ready [NI];
    logic [1:0]  rsp_valid [NI];
    logic [31:0] rsp_rdata [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [31:0] mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [3:0]  mem_wstrb [NI];
    logic [31:0] mem_rdata [NI];
    logic        end_flag  [NI];
    logic [31:0] end_data  [NI];

    int checks = 0;
    int failures = 0;
    int          model_ptr   [NI];
    logic        model_end_f [NI];
    logic [31:0] model_end_d [NI];
    int          grants[$];

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    function automatic logic [31:0] init_word(input int k, input int i);
        case (i)
            64:      return 32'hDEADBEEF;
            128:     return 32'h0BADF00D;
            192:     return 32'hAABBCCDD;
            default: return {16'hC0DE, 8'(k), 8'(i)};
        endcase
    endfunction

    // One DUT per latency, each with its own RAM model.
    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 5;
        logic [31:0] ram  [256];
        logic [31:0] pipe [L];

        soc_mem_arb #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .NUM_PORTS   (2),
            .MEM_LATENCY (L),
            .HALT_ADDR   (32'h1000_0000)
        ) u_dut (
            .i_sys_clk   (clk),
            .i_sys_rst_n (rst_n),
            .i_req_valid (req_valid[g]),
            .o_req_ready (req_ready[g]),
            .i_req_we    (req_we[g]),
            .i_req_addr  (req_addr[g]),
            .i_req_wdata (req_wdata[g]),
            .i_req_wstrb (req_wstrb[g]),
            .o_rsp_valid (rsp_valid[g]),
            .o_rsp_rdata (rsp_rdata[g]),
            .o_mem_en    (mem_en[g]),
            .o_mem_we    (mem_we[g]),
            .o_mem_addr  (mem_addr[g]),
            .o_mem_wdata (mem_wdata[g]),
            .o_mem_wstrb (mem_wstrb[g]),
            .i_mem_rdata (mem_rdata[g]),
            .o_end_flag  (end_flag[g]),
            .o_end_data  (end_data[g])
        );

        // RAM: data appears exactly L cycles after the enable cycle, junk otherwise.
        always @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i < 256; i++) ram[i] <= init_word(g, i);
                pipe[0] <= 32'hBAD0BAD0;
            end else if (mem_en[g]) begin
                pipe[0] <= ram[mem_addr[g][9:2]];
                if (mem_we[g])
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[g][b]) ram[mem_addr[g][9:2]][8*b +: 8] <= mem_wdata[g][8*b +: 8];
            end else begin
                pipe[0] <= 32'hBAD0BAD0;
            end
            for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        end
        assign mem_rdata[g] = pipe[L-1];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_port(input int k, input int p, input logic v, input logic we,
                              input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        req_valid[k][p]           = v;
        req_we[k][p]              = we;
        req_addr[k][p*32 +: 32]   = a;
        req_wdata[k][p*32 +: 32]  = wd;
        req_wstrb[k][p*4 +: 4]    = ws;
    endtask

    task automatic chk_all_zero(input int k, input string tag);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid[k]), 0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata[k]), 0);
        chk({tag, "_mem_en"},    64'(mem_en[k]), 0);
        chk({tag, "_mem_we"},    64'(mem_we[k]), 0);
        chk({tag, "_mem_addr"},  64'(mem_addr[k]), 0);
        chk({tag, "_mem_wdata"}, 64'(mem_wdata[k]), 0);
        chk({tag, "_mem_wstrb"}, 64'(mem_wstrb[k]), 0);
        chk({tag, "_end_flag"},  64'(end_flag[k]), 0);
        chk({tag, "_end_data"},  64'(end_data[k]), 0);
    endtask

    typedef struct {
        int          inst;
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          en;
        logic        end_f;
        logic [31:0] end_d;
    } vec_t;
    vec_t tbl [9];

    // Single isolated transaction: ready at T, memory in T+1, response at T+L+2.
    task automatic do_txn(input vec_t r);
        int k = r.inst;
        int L = lat_of(k);
        int en_cnt = 0;
        @(negedge clk);
        drive_port(k, r.port, 1'b1, r.we, r.addr, r.wdata, r.wstrb);
        #1;
        chk("txn_ready", 64'(req_ready[k]), 64'(1 << r.port));
        for (int j = 1; j <= L + 3; j++) begin
            @(negedge clk);
            if (j == 1) drive_port(k, r.port, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            #1;
            if (mem_en[k]) en_cnt++;
            if (j == 1) begin
                chk("txn_mem_en", 64'(mem_en[k]), 64'(r.en));
                chk("txn_end_flag_t1", 64'(end_flag[k]), 64'(model_end_f[k]));
                if (r.en == 1) begin
                    chk("txn_mem_we",    64'(mem_we[k]), 64'(r.we));
                    chk("txn_mem_addr",  64'(mem_addr[k]), 64'(r.addr));
                    chk("txn_mem_wstrb", 64'(mem_wstrb[k]), r.we ? 64'(r.wstrb) : 64'(mem_wstrb[k]));
                    if (r.we) chk("txn_mem_wdata", 64'(mem_wdata[k]), 64'(r.wdata));
                end
            end
            if (j == 2) begin
                chk("txn_end_flag", 64'(end_flag[k]), 64'(r.end_f));
                chk("txn_end_data", 64'(end_data[k]), 64'(r.end_d));
            end
            if (j == L + 2) begin
                chk("txn_rsp_valid", 64'(rsp_valid[k]), 64'(1 << r.port));
                chk("txn_rsp_rdata", 64'(rsp_rdata[k]), 64'(r.rdata));
            end else begin
                chk("txn_rsp_quiet", 64'(rsp_valid[k]), 0);
            end
        end
        chk("txn_mem_en_count", 64'(en_cnt), 64'(r.en));
        model_ptr[k]   = (r.port + 1) % 2;
        model_end_f[k] = r.end_f;
        model_end_d[k] = r.end_d;
    endtask

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
    } exp_rsp_t;

    // Transaction-level reference: one transaction per L+3 cycles, round-robin
    // order from a pointer, reads return a shadow memory updated by writes.
    task automatic run_traffic(input int k, input int ncyc, input int full, input int maxpp);
        int          L = lat_of(k);
        int          next_free = 0;
        int          hs_cyc = -100;
        int          stop_gen = ncyc - 4 * (L + 3);
        logic [31:0] refm [64];
        exp_rsp_t    q[$];
        logic        pend [2];
        logic        pwe  [2];
        logic [31:0] pa   [2];
        logic [31:0] pwd  [2];
        logic [3:0]  pws  [2];
        int          cnt  [2];
        int          win;
        int          outstanding;
        for (int i = 0; i < 64; i++) refm[i] = init_word(k, i);
        for (int p = 0; p < 2; p++) begin
            pend[p] = 1'b0; cnt[p] = 0; pwe[p] = 1'b0; pa[p] = '0; pwd[p] = '0; pws[p] = '0;
        end
        grants.delete();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && cnt[p] < maxpp && c < stop_gen && (full != 0 || $urandom_range(0, 1) == 1)) begin
                    pend[p] = 1'b1;
                    pwe[p]  = (full != 0) ? 1'b0 : ($urandom_range(0, 3) == 0);
                    pa[p]   = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
                    pwd[p]  = $urandom;
                    pws[p]  = 4'($urandom_range(0, 15));
                    cnt[p]++;
                end
                drive_port(k, p, pend[p], pwe[p], pa[p], pwd[p], pws[p]);
            end
            #1;
            win = -1;
            if (c >= next_free)
                for (int i = 0; i < 2; i++)
                    if (win < 0 && pend[(model_ptr[k] + i) % 2]) win = (model_ptr[k] + i) % 2;
            chk("rr_ready", 64'(req_ready[k]), (win < 0) ? 64'(0) : 64'(1 << win));
            chk("rr_mem_en", 64'(mem_en[k]), 64'(c == hs_cyc + 1));
            if (q.size() > 0 && q[0].cyc == c) begin
                chk("rr_rsp_valid", 64'(rsp_valid[k]), 64'(1 << q[0].port));
                chk("rr_rsp_rdata", 64'(rsp_rdata[k]), 64'(q[0].data));
                void'(q.pop_front());
            end else begin
                chk("rr_rsp_quiet", 64'(rsp_valid[k]), 0);
            end
            if (win >= 0) begin
                exp_rsp_t e;
                e.cyc  = c + L + 2;
                e.port = win;
                if (pwe[win]) begin
                    for (int b = 0; b < 4; b++)
                        if (pws[win][b]) refm[pa[win][7:2]][8*b +: 8] = pwd[win][8*b +: 8];
                    e.data = 32'h0;
                end else begin
                    e.data = refm[pa[win][7:2]];
                end
                q.push_back(e);
                grants.push_back(win);
                hs_cyc       = c;
                next_free    = c + L + 3;
                model_ptr[k] = (win + 1) % 2;
                pend[win]    = 1'b0;
            end
        end
        for (int p = 0; p < 2; p++) drive_port(k, p, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        outstanding = q.size();
        for (int p = 0; p < 2; p++) if (pend[p]) outstanding++;
        chk("rr_drained", 64'(outstanding), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < NI; k++) begin
            req_valid[k] = '0; req_we[k] = '0; req_addr[k] = '0; req_wdata[k] = '0; req_wstrb[k] = '0;
            model_ptr[k] = 0; model_end_f[k] = 1'b0; model_end_d[k] = '0;
        end
        tbl[0] = '{0, 0, 1'b0, 32'h0000_0100, 32'h0,          4'h0,   32'hDEADBEEF, 1, 1'b0, 32'h0};
        tbl[1] = '{1, 0, 1'b0, 32'h0000_0200, 32'h0,          4'h0,   32'h0BADF00D, 1, 1'b0, 32'h0};
        tbl[2] = '{2, 0, 1'b0, 32'h0000_0200, 32'h0,          4'h0,   32'h0BADF00D, 1, 1'b0, 32'h0};
        tbl[3] = '{3, 0, 1'b0, 32'h0000_0200, 32'h0,          4'h0,   32'h0BADF00D, 1, 1'b0, 32'h0};
        tbl[4] = '{0, 1, 1'b1, 32'h0000_0300, 32'h11223344,   4'b0101, 32'h0,       1, 1'b0, 32'h0};
        tbl[5] = '{0, 0, 1'b0, 32'h0000_0300, 32'h0,          4'h0,   32'hAA22CC44, 1, 1'b0, 32'h0};
        tbl[6] = '{0, 1, 1'b1, 32'h1000_0000, 32'h0000_002A,  4'hF,   32'h0,        0, 1'b1, 32'h2A};
        tbl[7] = '{0, 1, 1'b1, 32'h1000_0000, 32'h0000_0055,  4'hF,   32'h0,        0, 1'b1, 32'h2A};
        tbl[8] = '{0, 0, 1'b0, 32'h1000_0000, 32'h0,          4'h0,   32'h1,        0, 1'b1, 32'h2A};

        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) chk_all_zero(k, "in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            chk_all_zero(k, "after_reset");
            chk("after_reset_ready", 64'(req_ready[k]), 0);
        end

        // Both ports saturated with reads, four each: grants alternate from port 0.
        run_traffic(0, 60, 1, 4);
        chk("contention_count", 64'(grants.size()), 8);
        for (int i = 0; i < grants.size(); i++) chk("contention_order", 64'(grants[i]), 64'(i % 2));

        for (int t = 0; t < 9; t++) do_txn(tbl[t]);

        run_traffic(0, 400, 0, 1000);
        run_traffic(1, 400, 0, 1000);

        // Reset during WAIT on the latency-4 instance.
        @(negedge clk);
        drive_port(2, 0, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        #1;
        chk("rstmid_ready", 64'(req_ready[2]), 64'b01);
        @(negedge clk);
        drive_port(2, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        chk("rstmid_issue_en", 64'(mem_en[2]), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero(2, "rstmid");
        chk("rstmid_halt_cleared_flag", 64'(end_flag[0]), 0);
        chk("rstmid_halt_cleared_data", 64'(end_data[0]), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < NI; k++) begin
            model_ptr[k] = 0; model_end_f[k] = 1'b0; model_end_d[k] = '0;
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            #1;
            chk("rstmid_no_rsp", 64'(rsp_valid[2]), 0);
        end
        @(negedge clk);
        drive_port(2, 0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'h0);
        drive_port(2, 1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0);
        #1;
        chk("rstmid_regrant_p0", 64'(req_ready[2]), 64'b01);
        @(negedge clk);
        drive_port(2, 0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive_port(2, 1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
